// File: rtl/power_sample_capture.sv
// Multi-channel sample capture buffer: single-shot or ring-buffer mode, registered 1-cycle readout.
// Optional channel-0 rising-edge trigger enabled by the CAPTURE_TRIGGER_EN macro.
module power_sample_capture #(
    parameter int NUM_CH     = 6,
    parameter int SAMPLE_W   = 8,
    parameter int ADDR_W     = 12,
    parameter int TRIG_LEVEL = 128,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [NUM_CH*SAMPLE_W-1:0] channel_analog_export,
    input  logic                       read_new_sample_export,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       mode_continuous,
    input  logic [ADDR_W-1:0]          rd_address,
    input  logic [CH_W-1:0]            rd_channel,
    output logic [SAMPLE_W-1:0]        rd_data,
    output logic [ADDR_W-1:0]          write_address_export,
    output logic                       writing_finish_flag_export,
    output logic                       busy,
    output logic                       dropped_sample
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                      r_state;
    logic [ADDR_W-1:0]           r_wr_addr;
    logic                        r_flag;
    logic                        r_busy;
    logic                        r_dropped;
    logic                        r_mode;
    logic [SAMPLE_W-1:0]         r_rd_data;
    logic [NUM_CH*SAMPLE_W-1:0]  r_mem [0:DEPTH-1];

    logic                        w_trig;
    logic                        w_wr_en;
    logic [NUM_CH*SAMPLE_W-1:0]  w_rd_row;
    logic [SAMPLE_W-1:0]         w_rd_sel;

`ifdef CAPTURE_TRIGGER_EN
    localparam logic [SAMPLE_W-1:0] TRIG = SAMPLE_W'(TRIG_LEVEL);

    logic [SAMPLE_W-1:0] r_prev_ch0;
    logic                r_prev_vld;
    logic [SAMPLE_W-1:0] w_ch0;

    assign w_ch0  = channel_analog_export[SAMPLE_W-1:0];
    assign w_trig = r_prev_vld && (r_prev_ch0 < TRIG) && (w_ch0 >= TRIG);

    // Previous channel-0 sample; invalidated on arm so the first strobe never triggers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_prev_ch0 <= '0;
            r_prev_vld <= 1'b0;
        end else if (stop || arm) begin
            r_prev_vld <= 1'b0;
        end else if (r_state == S_ARMED && read_new_sample_export) begin
            r_prev_ch0 <= w_ch0;
            r_prev_vld <= 1'b1;
        end
    end
`else
    logic [SAMPLE_W-1:0] w_unused_trig;
    assign w_unused_trig = SAMPLE_W'(TRIG_LEVEL);
    assign w_trig        = 1'b0;
`endif

    // Stop and arm take priority over a coincident strobe; reset blocks writes immediately.
    assign w_wr_en = read_new_sample_export && !arm && !stop && !reset_reset &&
                     ((r_state == S_CAPTURE) || (r_state == S_ARMED && w_trig));

    always_ff @(posedge clk_clk) begin
        if (w_wr_en)
            r_mem[r_wr_addr] <= channel_analog_export;
    end

    assign w_rd_row = r_mem[rd_address];

    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(rd_channel) == k)
                w_rd_sel = w_rd_row[k*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            r_rd_data <= '0;
        else
            r_rd_data <= w_rd_sel;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state   <= S_IDLE;
            r_wr_addr <= '0;
            r_flag    <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
            r_mode    <= 1'b0;
        end else if (stop) begin
            r_state <= S_IDLE;
            r_flag  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (arm) begin
            r_wr_addr <= '0;
            r_flag    <= 1'b0;
            r_dropped <= 1'b0;
            r_mode    <= mode_continuous;
            r_busy    <= 1'b1;
`ifdef CAPTURE_TRIGGER_EN
            r_state   <= S_ARMED;
`else
            r_state   <= S_CAPTURE;
`endif
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (w_wr_en) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        r_state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Continuous mode: the flag is a one-cycle wrap pulse.
                    if (r_mode)
                        r_flag <= 1'b0;
                    if (w_wr_en) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (&r_wr_addr) begin
                            r_flag <= 1'b1;
                            if (!r_mode) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (read_new_sample_export)
                        r_dropped <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rd_data                    = r_rd_data;
    assign write_address_export       = r_wr_addr;
    assign writing_finish_flag_export = r_flag;
    assign busy                       = r_busy;
    assign dropped_sample             = r_dropped;

endmodule

// File: tb/tb_power_sample_capture.sv
// Directed bench for power_sample_capture (NUM_CH=6, SAMPLE_W=8, ADDR_W=4, default build).
module tb_power_sample_capture;

    localparam int NUM_CH   = 6;
    localparam int SAMPLE_W = 8;
    localparam int ADDR_W   = 4;
    localparam int CH_W     = 3;

    logic                       clk_clk = 1'b0;
    logic                       reset_reset;
    logic [NUM_CH*SAMPLE_W-1:0] channel_analog_export;
    logic                       read_new_sample_export;
    logic                       arm;
    logic                       stop;
    logic                       mode_continuous;
    logic [ADDR_W-1:0]          rd_address;
    logic [CH_W-1:0]            rd_channel;
    logic [SAMPLE_W-1:0]        rd_data;
    logic [ADDR_W-1:0]          write_address_export;
    logic                       writing_finish_flag_export;
    logic                       busy;
    logic                       dropped_sample;

    int n_checks = 0;
    int n_fail   = 0;
    int n_flag   = 0;

    power_sample_capture #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .TRIG_LEVEL(128)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .channel_analog_export(channel_analog_export),
        .read_new_sample_export(read_new_sample_export),
        .arm(arm),
        .stop(stop),
        .mode_continuous(mode_continuous),
        .rd_address(rd_address),
        .rd_channel(rd_channel),
        .rd_data(rd_data),
        .write_address_export(write_address_export),
        .writing_finish_flag_export(writing_finish_flag_export),
        .busy(busy),
        .dropped_sample(dropped_sample)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_data(input int base, input int step);
        for (int k = 0; k < NUM_CH; k++)
            channel_analog_export[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(base + step * k);
    endtask

    task automatic strobe_once();
        read_new_sample_export = 1'b1;
        tick();
        read_new_sample_export = 1'b0;
    endtask

    task automatic pulse_arm(input logic mode);
        mode_continuous = mode;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr, input int ch, input int exp);
        rd_address = ADDR_W'(addr);
        rd_channel = CH_W'(ch);
        tick();
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        reset_reset = 1'b1;
        channel_analog_export = '0;
        read_new_sample_export = 1'b0;
        arm = 1'b0;
        stop = 1'b0;
        mode_continuous = 1'b0;
        rd_address = '0;
        rd_channel = '0;
        tick();
        tick();
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_waddr", 32'(write_address_export), 0);
        check("rst_flag", 32'(writing_finish_flag_export), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dropped", 32'(dropped_sample), 0);
        reset_reset = 1'b0;
        tick();

        // Single-shot fill: channel k of strobe n = 6n+k
        pulse_arm(1'b0);
        check("ss_busy_armed", 32'(busy), 1);
        for (int n = 0; n < 16; n++) begin
            set_data(6 * n, 1);
            strobe_once();
        end
        check("ss_flag", 32'(writing_finish_flag_export), 1);
        check("ss_waddr", 32'(write_address_export), 0);
        check("ss_busy_done", 32'(busy), 0);
        read_check("ss_rd_5_2", 5, 2, 32);
        read_check("ss_rd_15_5", 15, 5, 95);

        // Strobes in DONE are dropped
        for (int i = 0; i < 3; i++) begin
            set_data(255, 0);
            strobe_once();
        end
        check("done_dropped", 32'(dropped_sample), 1);
        check("done_flag_held", 32'(writing_finish_flag_export), 1);
        read_check("done_rd_0_0", 0, 0, 0);
        read_check("done_rd_5_2", 5, 2, 32);

        // Arm with a coincident strobe: strobe ignored
        set_data(238, 0);
        read_new_sample_export = 1'b1;
        pulse_arm(1'b0);
        read_new_sample_export = 1'b0;
        check("rearm_dropped", 32'(dropped_sample), 0);
        check("rearm_flag", 32'(writing_finish_flag_export), 0);
        check("rearm_busy", 32'(busy), 1);
        check("rearm_waddr", 32'(write_address_export), 0);
        read_check("rearm_rd_0_0", 0, 0, 0);

        // Continuous mode, restarted mid-capture: strobe n (1..40) carries 7n+k
        pulse_arm(1'b1);
        for (int n = 1; n <= 40; n++) begin
            set_data(7 * n, 1);
            strobe_once();
            if (writing_finish_flag_export) n_flag++;
            if (n == 16 || n == 32)
                check($sformatf("cont_flag_s%0d", n), 32'(writing_finish_flag_export), 1);
            tick();
            if (writing_finish_flag_export) n_flag++;
            if (n == 16 || n == 32)
                check($sformatf("cont_flag_off_s%0d", n), 32'(writing_finish_flag_export), 0);
        end
        check("cont_flag_count", 32'(n_flag), 2);
        check("cont_waddr", 32'(write_address_export), 8);
        check("cont_busy", 32'(busy), 1);
        read_check("cont_rd_3_0", 3, 0, 252);
        read_check("cont_rd_3_5", 3, 5, 1);

        // Stop wins over arm; no further writes
        set_data(85, 0);
        read_new_sample_export = 1'b1;
        arm = 1'b1;
        stop = 1'b1;
        tick();
        arm = 1'b0;
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        strobe_once();
        strobe_once();
        check("stop_waddr", 32'(write_address_export), 8);
        check("stop_flag", 32'(writing_finish_flag_export), 0);
        read_check("stop_rd_8_0", 8, 0, 175);
        read_check("stop_rd_ch7", 8, 7, 0);

        // Read-during-write returns old data, then reset mid-capture at address 7
        rd_address = '0;
        rd_channel = '0;
        pulse_arm(1'b0);
        for (int n = 0; n < 7; n++) begin
            set_data(3 * n + 1, 1);
            strobe_once();
            if (n == 0) check("rdw_old", 32'(rd_data), 231);
            if (n == 1) check("rdw_new", 32'(rd_data), 1);
        end
        check("pre_rst_waddr", 32'(write_address_export), 7);
        set_data(170, 0);
        read_new_sample_export = 1'b1;
        #2;
        reset_reset = 1'b1;
        #1;
        check("arst_rd_data", 32'(rd_data), 0);
        check("arst_waddr", 32'(write_address_export), 0);
        check("arst_flag", 32'(writing_finish_flag_export), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_dropped", 32'(dropped_sample), 0);
        tick();
        tick();
        read_new_sample_export = 1'b0;
        reset_reset = 1'b0;
        tick();
        read_check("keep_rd_0_0", 0, 0, 1);
        read_check("keep_rd_6_4", 6, 4, 23);
        read_check("keep_rd_7_0", 7, 0, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
